// File: rtl/instr_fetch.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Brief    : Fetch stage with IF/ID register, stall hold buffer and redirect drain
// Revision : 1.0
// ============================================================================
module instr_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        addr_sel,
  input  logic        br_sel,
  input  logic        special_addr_sel,
  input  logic        flush,
  input  logic [18:0] cond_offset_raw,
  input  logic [25:0] br_offset_raw,
  input  logic [63:0] br_target_reg,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [63:0] pc_id,
  output logic        valid_id
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] drain_addr_q, drain_addr_d;
  logic [31:0] hold_buf_q, hold_buf_d;
  logic [31:0] instr_q, instr_d;
  logic [63:0] pc_id_q, pc_id_d;
  logic        valid_q, valid_d;

  logic        redirect;
  logic [63:0] target;
  logic [63:0] cond_off;
  logic [63:0] br_off;

  assign cond_off = {{43{cond_offset_raw[18]}}, cond_offset_raw, 2'b00};
  assign br_off   = {{36{br_offset_raw[25]}}, br_offset_raw, 2'b00};

  // A bubble in IF/ID can never redirect, whatever decode drives on addr_sel.
  assign redirect = addr_sel & valid_q & ~stall;

  always_comb begin
    target = pc_id_q + cond_off;
    if (special_addr_sel) begin
      target = br_target_reg;
    end else if (br_sel) begin
      target = pc_id_q + br_off;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    hold_buf_d   = hold_buf_q;
    instr_d      = instr_q;
    pc_id_d      = pc_id_q;
    valid_d      = valid_q;

    case (state_q)
      FETCH: begin
        if (redirect) begin
          pc_d    = target;
          instr_d = 32'h0;
          valid_d = 1'b0;
          if (!imem_ack) begin
            // Request already issued: keep presenting it until the ack arrives.
            drain_addr_d = pc_q;
            state_d      = DRAIN;
          end
        end else if (imem_ack) begin
          pc_d = pc_q + 64'd4;
          if (stall) begin
            hold_buf_d = imem_rdata;
            state_d    = HOLD;
          end else if (flush) begin
            instr_d = 32'h0;
            valid_d = 1'b0;
          end else begin
            instr_d = imem_rdata;
            pc_id_d = pc_q;
            valid_d = 1'b1;
          end
        end else if (!stall) begin
          instr_d = 32'h0;
          valid_d = 1'b0;
        end
      end

      HOLD: begin
        if (redirect) begin
          pc_d    = target;
          instr_d = 32'h0;
          valid_d = 1'b0;
          state_d = FETCH;
        end else if (!stall) begin
          state_d = FETCH;
          if (flush) begin
            instr_d = 32'h0;
            valid_d = 1'b0;
          end else begin
            instr_d = hold_buf_q;
            pc_id_d = pc_q - 64'd4;
            valid_d = 1'b1;
          end
        end
      end

      DRAIN: begin
        if (redirect) begin
          pc_d    = target;
          instr_d = 32'h0;
          valid_d = 1'b0;
        end else if (!stall) begin
          instr_d = 32'h0;
          valid_d = 1'b0;
        end
        if (imem_ack) begin
          state_d = FETCH;
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= FETCH;
      pc_q         <= 64'h0;
      drain_addr_q <= 64'h0;
      hold_buf_q   <= 32'h0;
      instr_q      <= 32'h0;
      pc_id_q      <= 64'h0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      hold_buf_q   <= hold_buf_d;
      instr_q      <= instr_d;
      pc_id_q      <= pc_id_d;
      valid_q      <= valid_d;
    end
  end

  assign imem_req    = (state_q != HOLD);
  assign imem_addr   = (state_q == DRAIN) ? drain_addr_q : pc_q;
  assign instruction = instr_q;
  assign pc_id       = pc_id_q;
  assign valid_id    = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch
// Brief    : Directed vector table plus hand sequences for instr_fetch
// Revision : 1.0
// ============================================================================
module tb_instr_fetch;

  typedef struct packed {
    logic        stall;
    logic        addr_sel;
    logic        br_sel;
    logic        special_addr_sel;
    logic        flush;
    logic [18:0] cond_offset_raw;
    logic [25:0] br_offset_raw;
    logic [63:0] br_target_reg;
    logic        imem_ack;
    logic [31:0] imem_rdata;
  } in_t;

  typedef struct packed {
    logic        req;
    logic [63:0] addr;
    logic [31:0] instr;
    logic [63:0] pcid;
    logic        valid;
    in_t         in;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall, addr_sel, br_sel, special_addr_sel, flush;
  logic [18:0] cond_offset_raw;
  logic [25:0] br_offset_raw;
  logic [63:0] br_target_reg;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [63:0] pc_id;
  logic        valid_id;

  int n_tests = 0;
  int n_fail  = 0;

  instr_fetch dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .addr_sel         (addr_sel),
    .br_sel           (br_sel),
    .special_addr_sel (special_addr_sel),
    .flush            (flush),
    .cond_offset_raw  (cond_offset_raw),
    .br_offset_raw    (br_offset_raw),
    .br_target_reg    (br_target_reg),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ack         (imem_ack),
    .imem_rdata       (imem_rdata),
    .instruction      (instruction),
    .pc_id            (pc_id),
    .valid_id         (valid_id)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected to finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input in_t v);
    stall            = v.stall;
    addr_sel         = v.addr_sel;
    br_sel           = v.br_sel;
    special_addr_sel = v.special_addr_sel;
    flush            = v.flush;
    cond_offset_raw  = v.cond_offset_raw;
    br_offset_raw    = v.br_offset_raw;
    br_target_reg    = v.br_target_reg;
    imem_ack         = v.imem_ack;
    imem_rdata       = v.imem_rdata;
  endtask

  function automatic in_t mk_in(input logic ack, input logic [31:0] rd,
                                input logic st, input logic fl, input logic as,
                                input logic bs, input logic [25:0] bo);
    in_t v = '0;
    v.imem_ack = ack;  v.imem_rdata = rd;
    v.stall = st;      v.flush = fl;
    v.addr_sel = as;   v.br_sel = bs;   v.br_offset_raw = bo;
    return v;
  endfunction

  function automatic vec_t mk_vec(input logic req, input logic [63:0] addr,
                                  input logic [31:0] ins, input logic [63:0] pcid,
                                  input logic vld, input in_t in);
    vec_t v;
    v.req = req; v.addr = addr; v.instr = ins; v.pcid = pcid; v.valid = vld; v.in = in;
    return v;
  endfunction

  // Leaves the bench on a falling edge with reset released and reset-state outputs.
  task automatic do_reset();
    reset = 1'b1;
    drive('0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Zero-wait fetch of n sequential words starting at address 0.
  task automatic fetch_seq(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      chk("seq_addr", imem_addr, 64'(i * 4));
      drive(mk_in(1'b1, base + 32'(i), 1'b0, 1'b0, 1'b0, 1'b0, 26'h0));
      @(negedge clk);
    end
  endtask

  vec_t tbl [14];
  in_t  v;

  initial begin
    tbl[0]  = mk_vec(1, 64'h00, 32'h0,        64'h00, 0, mk_in(1, 32'h1111_0000, 0, 0, 0, 0, 26'h0));
    tbl[1]  = mk_vec(1, 64'h04, 32'h1111_0000, 64'h00, 1, mk_in(1, 32'h2222_0000, 0, 0, 0, 0, 26'h0));
    tbl[2]  = mk_vec(1, 64'h08, 32'h2222_0000, 64'h04, 1, mk_in(1, 32'h3333_0000, 0, 0, 0, 0, 26'h0));
    tbl[3]  = mk_vec(1, 64'h0C, 32'h3333_0000, 64'h08, 1, mk_in(0, 32'h0,         0, 0, 0, 0, 26'h0));
    tbl[4]  = mk_vec(1, 64'h0C, 32'h0,        64'h00, 0, mk_in(1, 32'h4444_0000, 0, 0, 0, 0, 26'h0));
    tbl[5]  = mk_vec(1, 64'h10, 32'h4444_0000, 64'h0C, 1, mk_in(1, 32'h5555_0000, 1, 0, 0, 0, 26'h0));
    tbl[6]  = mk_vec(0, 64'h00, 32'h4444_0000, 64'h0C, 1, mk_in(1, 32'hBAD0_0000, 1, 0, 0, 0, 26'h0));
    tbl[7]  = mk_vec(0, 64'h00, 32'h4444_0000, 64'h0C, 1, mk_in(0, 32'h0,         0, 0, 0, 0, 26'h0));
    tbl[8]  = mk_vec(1, 64'h14, 32'h5555_0000, 64'h10, 1, mk_in(1, 32'h6666_0000, 0, 1, 0, 0, 26'h0));
    tbl[9]  = mk_vec(1, 64'h18, 32'h0,        64'h00, 0, mk_in(1, 32'h7777_0000, 0, 0, 1, 0, 26'h0));
    tbl[10] = mk_vec(1, 64'h1C, 32'h7777_0000, 64'h18, 1, mk_in(1, 32'h8888_0000, 0, 0, 1, 1, 26'h4));
    tbl[11] = mk_vec(1, 64'h28, 32'h0,        64'h00, 0, mk_in(1, 32'h9999_0000, 0, 0, 0, 0, 26'h0));
    tbl[12] = mk_vec(1, 64'h2C, 32'h9999_0000, 64'h28, 1, mk_in(0, 32'h0,         0, 0, 0, 0, 26'h0));
    tbl[13] = mk_vec(1, 64'h2C, 32'h0,        64'h00, 0, mk_in(0, 32'h0,         0, 0, 0, 0, 26'h0));

    // Reset state
    drive('0);
    @(negedge clk);
    chk("rst_instr", 64'(instruction), 64'h0);
    chk("rst_pc_id", pc_id, 64'h0);
    chk("rst_valid", 64'(valid_id), 64'h0);
    do_reset();
    chk("rst_req", 64'(imem_req), 64'h1);
    chk("rst_addr", imem_addr, 64'h0);

    // Vector table: streaming, bubble, stall/hold, flush, masked and real redirect
    for (int i = 0; i < 14; i++) begin
      chk($sformatf("v%0d_req", i), 64'(imem_req), 64'(tbl[i].req));
      if (tbl[i].req) chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("v%0d_instr", i), 64'(instruction), 64'(tbl[i].instr));
      chk($sformatf("v%0d_valid", i), 64'(valid_id), 64'(tbl[i].valid));
      if (tbl[i].valid) chk($sformatf("v%0d_pc_id", i), pc_id, tbl[i].pcid);
      drive(tbl[i].in);
      @(negedge clk);
    end

    // Conditional branch backwards by two words from 0x40
    do_reset();
    fetch_seq(17, 32'h1000_0000);
    chk("cond_pc_id", pc_id, 64'h40);
    chk("cond_valid", 64'(valid_id), 64'h1);
    v = mk_in(1'b1, 32'hDEAD_0044, 1'b0, 1'b0, 1'b1, 1'b0, 26'h0);
    v.cond_offset_raw = 19'h7FFFE;
    drive(v);
    @(negedge clk);
    chk("cond_addr", imem_addr, 64'h38);
    chk("cond_bubble_valid", 64'(valid_id), 64'h0);
    chk("cond_bubble_instr", 64'(instruction), 64'h0);

    // Unconditional branch with most-negative offset, wrapping below zero
    do_reset();
    fetch_seq(65, 32'h2000_0000);
    chk("uncond_pc_id", pc_id, 64'h100);
    drive(mk_in(1'b1, 32'hDEAD_0104, 1'b0, 1'b0, 1'b1, 1'b1, 26'h2000000));
    @(negedge clk);
    chk("uncond_addr", imem_addr, 64'hFFFF_FFFF_F800_0100);
    chk("uncond_valid", 64'(valid_id), 64'h0);

    // Register redirect while the outstanding fetch is acked three cycles late
    do_reset();
    fetch_seq(1, 32'h3000_0000);
    chk("drain_pre_valid", 64'(valid_id), 64'h1);
    v = mk_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 26'h0);
    v.special_addr_sel = 1'b1;
    v.br_target_reg    = 64'h1000;
    drive(v);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("drain%0d_req", k), 64'(imem_req), 64'h1);
      chk($sformatf("drain%0d_addr", k), imem_addr, 64'h4);
      chk($sformatf("drain%0d_valid", k), 64'(valid_id), 64'h0);
      drive(mk_in(k == 2, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0, 26'h0));
      @(negedge clk);
    end
    chk("drain_new_addr", imem_addr, 64'h1000);
    chk("drain_discard_valid", 64'(valid_id), 64'h0);
    chk("drain_discard_instr", 64'(instruction), 64'h0);
    drive(mk_in(1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0, 26'h0));
    @(negedge clk);
    chk("drain_tgt_instr", 64'(instruction), 64'h1234_5678);
    chk("drain_tgt_pc_id", pc_id, 64'h1000);
    chk("drain_next_addr", imem_addr, 64'h1004);

    // Four-cycle stall beginning with the ack of the word at 0x8
    do_reset();
    fetch_seq(2, 32'h4000_0000);
    chk("hold_addr", imem_addr, 64'h8);
    drive(mk_in(1'b1, 32'hCAFE_0008, 1'b1, 1'b0, 1'b0, 1'b0, 26'h0));
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("hold%0d_req", k), 64'(imem_req), 64'h0);
      chk($sformatf("hold%0d_instr", k), 64'(instruction), 64'h4000_0001);
      chk($sformatf("hold%0d_pc_id", k), pc_id, 64'h4);
      drive(mk_in(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 26'h0));
      @(negedge clk);
    end
    chk("hold3_req", 64'(imem_req), 64'h0);
    drive('0);
    @(negedge clk);
    chk("hold_out_instr", 64'(instruction), 64'hCAFE_0008);
    chk("hold_out_pc_id", pc_id, 64'h8);
    chk("hold_out_valid", 64'(valid_id), 64'h1);
    chk("hold_out_req", 64'(imem_req), 64'h1);
    chk("hold_out_addr", imem_addr, 64'hC);

    // Asynchronous reset in the middle of an outstanding request at 0x20
    do_reset();
    fetch_seq(8, 32'h5000_0000);
    chk("arst_pre_addr", imem_addr, 64'h20);
    chk("arst_pre_valid", 64'(valid_id), 64'h1);
    drive('0);
    #2 reset = 1'b1;
    #1;
    chk("arst_instr", 64'(instruction), 64'h0);
    chk("arst_pc_id", pc_id, 64'h0);
    chk("arst_valid", 64'(valid_id), 64'h0);
    chk("arst_addr", imem_addr, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    chk("arst_rel_req", 64'(imem_req), 64'h1);
    chk("arst_rel_addr", imem_addr, 64'h0);
    drive(mk_in(1'b1, 32'h0000_0055, 1'b0, 1'b0, 1'b0, 1'b0, 26'h0));
    @(negedge clk);
    chk("arst_first_instr", 64'(instruction), 64'h55);
    chk("arst_first_pc_id", pc_id, 64'h0);
    drive('0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
